// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind uart_rx: first-word fall-through read port, fill level,
// sticky overflow and saturating parity-error count. Optional macro: RX_FIFO_PARITY_DROP_EN.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       wr_valid,
    input  logic                       wr_perr,
    input  logic                       clear,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [7:0]                 perr_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       perr_cnt_q, perr_cnt_d;

    logic wr_accept;
    logic push;
    logic pop;
    logic drop_full;
    logic full_w;
    logic empty_w;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // Parity-failed bytes can be excluded from storage entirely; they still count as errors.
`ifdef RX_FIFO_PARITY_DROP_EN
    assign wr_accept = wr_valid && !wr_perr;
`else
    assign wr_accept = wr_valid;
`endif

    assign pop       = !empty_w && rd_ready && !clear;
    assign push      = wr_accept && !clear && (!full_w || pop);
    assign drop_full = wr_accept && !clear && full_w && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        perr_cnt_d = perr_cnt_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            perr_cnt_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            if (drop_full) overflow_d = 1'b1;
            if (wr_valid && wr_perr && (perr_cnt_q != 8'hFF))
                perr_cnt_d = perr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            perr_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            perr_cnt_q <= perr_cnt_d;
        end
    end

    // Storage is intentionally not reset; empty gating below hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_valid = !empty_w;
    assign rd_data  = empty_w ? '0 : mem[rd_ptr_q];
    assign count    = count_q;
    assign full     = full_w;
    assign empty    = empty_w;
    assign overflow = overflow_q;
    assign perr_cnt = perr_cnt_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of `uart_rx` in the UART path. It captures each completed receive byte strobe into a circular FIFO and presents bytes to the consumer (`seg7_display` feed or `uart_tx` echo logic) through a valid/ready handshake. Slow consumers therefore no longer lose characters. It also reports fill level, overflow, and parity-error statistics.

## Interface
Parameters:
- `DEPTH`, 16: number of byte slots; power of two, ≥ 2.
- `WIDTH`, 8: data width in bits.

Ports:
- `clk`  in  1  single clock; same domain as the producing `uart_rx` instance.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `wr_data`  in  WIDTH  received byte from `uart_rx`.
- `wr_valid`  in  1  one-cycle strobe: `wr_data` is a completed byte.
- `wr_perr`  in  1  parity error flag qualifying `wr_data`; sampled with `wr_valid`.
- `clear`  in  1  synchronous flush.
- `rd_data`  out  WIDTH  head-of-FIFO byte (first-word fall-through).
- `rd_valid`  out  1  `rd_data` holds a valid byte.
- `rd_ready`  in  1  consumer accepts `rd_data`; a pop occurs when `rd_valid && rd_ready`.
- `count`  out  log2(DEPTH)+1  bytes currently stored.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `perr_cnt`  out  8  saturating count of bytes received with parity error.

## Operation
- Storage: `DEPTH` x `WIDTH` register array (memory not reset); write pointer and read pointer are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Push condition: `wr_valid && !clear && (!full || pop)`. A push writes `mem[wr_ptr]` and then increments `wr_ptr`.
- Pop condition: `rd_valid && rd_ready && !clear`. A pop increments `rd_ptr`.
- `count`:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - Never exceeds DEPTH and never underflows.
- Full with simultaneous pop: the write is accepted and `count` stays at DEPTH.
- Full without pop and `wr_valid` = 1: byte discarded, `overflow` set to 1, pointers unchanged.
- Empty: `rd_valid` = 0, `rd_data` forced to 0. `rd_ready` is ignored.
- `overflow` remains set until `clear` or reset.
- `perr_cnt`:
  - increments on every `wr_valid` with `wr_perr` = 1, whether or not the byte is stored.
  - saturates at 255.
- `clear` = 1 (synchronous, highest priority):
  - next cycle, pointers and `count` are 0.
  - `overflow` = 0 and `perr_cnt` = 0.
  - any same-cycle push or pop is ignored.
- Asynchronous reset assertion mid-operation: all state is lost immediately. Stored bytes are not recoverable.

## Timing
- Reset values: `rd_data` = 0, `rd_valid` = 0, `count` = 0, `full` = 0, `empty` = 1, `overflow` = 0, `perr_cnt` = 0.
- Write-to-read latency: a byte pushed at edge N appears on `rd_data` with `rd_valid` = 1 after edge N, i.e. one cycle, including when the FIFO was previously empty.
- `rd_data` and `rd_valid` are combinational from the pointers and the array. Both are stable throughout the cycle between edges. The consumer may sample them in the same cycle it asserts `rd_ready`.
- After a pop at edge N, the next byte (if any) is presented after edge N.
- `count`, `full`, `empty`, `overflow`, `perr_cnt` are registered and update at the edge where the causing event is sampled.
- Back-to-back `wr_valid` on consecutive cycles is supported. Sustained throughput is one push and one pop per cycle.

## Configuration
- Macro: `RX_FIFO_PARITY_DROP_EN`.
- Defined:
  - bytes arriving with `wr_perr` = 1 are not stored.
  - no pointer or `count` change and no effect on `overflow`.
  - `perr_cnt` still increments.
- Undefined:
  - bytes with `wr_perr` = 1 are stored like any other byte.
  - `perr_cnt` still counts them.

## Test plan
- Reset then push 0x41, 0x42, 0x43 with `rd_ready` = 0:
  - `count` = 3, `rd_data` = 0x41, `rd_valid` = 1.
  - Then hold `rd_ready` = 1 for 3 cycles: `rd_data` steps 0x42, 0x43, then `empty` = 1 and `rd_data` = 0.
- Push 16 bytes 0x00–0x0F, then push 0xAA with no pop:
  - `full` = 1, `overflow` = 1, `count` = 16.
  - Draining yields 0x00–0x0F only.
- With the FIFO full, push 0x55 in the same cycle as a pop:
  - `count` stays 16, no overflow.
  - The last byte drained is 0x55.
- Pointer wrap: push and pop 40 bytes continuously. Output order equals input order and `count` never exceeds 1.
- Push 0x7E with `wr_perr` = 1:
  - `perr_cnt` = 1 in both configurations.
  - `count` = 1 without the macro; `count` = 0 with `RX_FIFO_PARITY_DROP_EN` defined.
- With 5 bytes stored and `overflow` set:
  - assert `clear` together with `wr_valid`: next cycle `count` = 0, `overflow` = 0, `perr_cnt` = 0, `empty` = 1.
  - assert `reset` = 0 mid-stream: all outputs return to their reset values immediately.
